// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: shift op encodings and the shift sequencer FSM states.
package mips_pkg;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_LSL2 = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One reusable shift stage: shifts data by 1 or by 4 in either direction with zero or sign fill.
module shift_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    input  logic             dir,    // 0 = left, 1 = right
    input  logic             arith,  // right shifts replicate the MSB
    input  logic             by4,
    output logic [WIDTH-1:0] data_out
);

    logic fill;

    always_comb begin
        fill = arith & data[WIDTH-1];
        data_out = data;
        case ({dir, by4})
            2'b00: data_out = {data[WIDTH-2:0], 1'b0};
            2'b01: data_out = {data[WIDTH-5:0], 4'b0000};
            2'b10: data_out = {fill, data[WIDTH-1:1]};
            2'b11: data_out = {{4{fill}}, data[WIDTH-1:4]};
            default: data_out = data;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: accepts one request, walks it through a shared by-1/by-4 stage, then holds the result.
module shift_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   operand,
    output logic [WIDTH-1:0]   result,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               busy,
    output state_t             dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // start_ready and result_valid are decoded from the state register only.

    localparam logic [SHAMT_W-1:0] REM_ONE  = SHAMT_W'(1);
    localparam logic [SHAMT_W-1:0] REM_TWO  = SHAMT_W'(2);
    localparam logic [SHAMT_W-1:0] REM_FOUR = SHAMT_W'(4);

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [1:0]         op_q, op_d;

    logic             step_dir;
    logic             step_arith;
    logic             step_by4;
    logic [WIDTH-1:0] step_out;

    assign step_dir   = (op_q == OP_SRL) || (op_q == OP_SRA);
    assign step_arith = (op_q == OP_SRA);
    assign step_by4   = (rem_q >= REM_FOUR);

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data     (work_q),
        .dir      (step_dir),
        .arith    (step_arith),
        .by4      (step_by4),
        .data_out (step_out)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        work_d  = work_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    work_d  = operand;
                    // LSL2 is just SLL by a fixed amount once latched
                    op_d    = (op == OP_LSL2) ? OP_SLL : op;
                    rem_d   = (op == OP_LSL2) ? REM_TWO : shamt;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (rem_q == '0) begin
                    state_d = DONE;
                end else begin
                    work_d = step_out;
                    rem_d  = rem_q - (step_by4 ? REM_FOUR : REM_ONE);
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            work_q  <= '0;
            op_q    <= OP_SLL;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            work_q  <= work_d;
            op_q    <= op_d;
        end
    end

    assign start_ready  = (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign result       = work_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller for the MIPS datapath. It accepts one shift request through a valid/ready handshake and runs it over several cycles using a single reusable shift stage (shift by 1 or by 4 per cycle). It then presents the result with valid/ready backpressure. It sits between the decode/ALU issue logic and the writeback mux, replacing a full barrel shifter. It also serves the fixed left-shift-by-2 needed for branch offsets.

## Interface
Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH).

Ports. Single clock `clk`; reset `rst_n` is synchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start_valid  in  1  request present.
- start_ready  out  1  block can accept a request; high only in IDLE.
- op  in  2  00 SLL, 01 SRL, 10 SRA, 11 LSL2 (fixed shift-left-by-2, shamt ignored).
- shamt  in  SHAMT_W  shift amount, 0..WIDTH-1.
- operand  in  WIDTH  value to shift.
- result  out  WIDTH  shifted value; meaningful only while result_valid.
- result_valid  out  1  result available; high only in DONE.
- result_ready  in  1  consumer takes result.
- busy  out  1  high in SHIFT or DONE.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - start_ready=1.
  - On start_valid, latch operand into the work register.
  - Latch op; latch rem=shamt, or rem=2 for LSL2. LSL2 is then executed as SLL.
  - Go to SHIFT.
- SHIFT, each cycle:
  - rem==0: go to DONE with no shift.
  - rem>=4: shift the work register by 4, rem-=4.
  - 1<=rem<=3: shift by 1, rem-=1.
- Shift fill rules:
  - SLL fills zeros at the LSB.
  - SRL fills zeros at the MSB.
  - SRA replicates the current work-register MSB. Sign is preserved across steps, so the result equals an arithmetic shift of the original operand.
- DONE:
  - result_valid=1 and result = work register.
  - Hold result and result_valid stable until result_ready=1.
  - On result_ready, go to IDLE.
- Inputs are ignored outside the accepting IDLE cycle. Changes to operand, op or shamt during SHIFT or DONE have no effect.
- No new request is accepted in DONE. A back-to-back request is accepted on the cycle after the handshake (one IDLE bubble).
- Reset: at any state, including mid-shift or while result_valid is stalled, the next edge with rst_n=0 has these effects:
  - state=IDLE;
  - result=0, result_valid=0, busy=0, start_ready=1;
  - rem=0;
  - the in-flight request is discarded.

## Timing
- Step count k = floor(s/4) + (s mod 4), where s is the effective shamt (2 for LSL2). Maximum k = 7+3 = 10 at s=31.
- Latency: a request accepted at edge E0 raises result_valid after edge E0+k+1. For s=0 that is E0+1.
- Throughput: one request per k+3 cycles with result_ready held high.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- start_ready depends only on state. It never depends on start_valid.

## Structure
- Shared package `mips_pkg` holds:
  - the op encodings (OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_LSL2=2'b11);
  - the FSM state typedef (IDLE, SHIFT, DONE).
- Sub-module `shift_step` is purely combinational. It takes data[WIDTH], dir/arith (from op) and by4, and outputs data shifted by 1 or 4 with the correct fill.
- The sequencer holds the FSM, the rem counter and the work register.

## Test plan
- SLL, operand 0x0000_0001, shamt 31 → result 0x8000_0000; result_valid 11 cycles after accept; busy high throughout.
- SRA, operand 0x8000_0000, shamt 4 → 0xF800_0000 at latency 2. SRL with the same inputs → 0x0800_0000.
- LSL2, operand 0x0000_0003, shamt 17 (ignored) → 0x0000_000C at latency 3.
- shamt 0 (SRL) with operand 0xDEAD_BEEF → 0xDEAD_BEEF at latency 1.
- Backpressure: hold result_ready=0 for 5 cycles in DONE → result and result_valid stable, start_ready=0. Then result_ready=1 → IDLE next cycle. A queued start_valid is accepted on the following edge.
- Reset mid-op: rst_n=0 during SHIFT of shamt 31 → next edge shows IDLE, result=0, result_valid=0. A new request then completes correctly.
